// File: rtl/trivium_ctrl.sv
// Sequencer for a trivium keystream core: latch key/IV, load, discard warm-up rounds, pack keystream MSB-first.
// Optional word-count limit with a done pulse is enabled by defining TRIVIUM_CTRL_LEN_LIMIT_EN.
module trivium_ctrl #(
  parameter int WORD_W        = 8,
  parameter int WARMUP_CYCLES = 1152,
  parameter int WCNT_W        = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [79:0]       key,
  input  logic [79:0]       iv,
  output logic              busy,
  output logic              core_load,
  output logic [79:0]       core_key,
  output logic [79:0]       core_iv,
  output logic              core_enable,
  input  logic              core_ks_bit,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
  ,
  input  logic [15:0]       len_words,
  output logic              done
`endif
);

  localparam int BCNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_t;

  state_t            state, next_state;
  logic              start_armed;
  logic              accept_start;
  logic              abort;
  logic              warm_done;
  logic              word_last;
  logic              handshake;
  logic              limit_hit;
  logic [WCNT_W-1:0] warm_cnt;
  logic [BCNT_W-1:0] bit_cnt;
  logic [WORD_W-2:0] shift;
  logic [WORD_W-1:0] shift_next;

  assign abort      = (state != IDLE) && stop;
  assign warm_done  = (warm_cnt == WCNT_W'(WARMUP_CYCLES - 1));
  assign word_last  = (bit_cnt == BCNT_W'(WORD_W - 1));
  assign handshake  = out_valid && out_ready;
  assign shift_next = {shift, core_ks_bit};

`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
  logic [15:0] len_lat;
  logic [15:0] hs_cnt;
  // A latched length of zero means the stream never ends on its own
  assign limit_hit = (state == RUN) && (len_lat != 16'd0) && handshake &&
                     (hs_cnt == len_lat - 16'd1);
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Core stalls only when a finished word is waiting and the next one would overwrite it
  always_comb begin
    next_state   = state;
    busy         = (state != IDLE);
    core_load    = (state == LOAD);
    core_enable  = 1'b0;
    accept_start = 1'b0;
    case (state)
      IDLE: begin
        if (start && start_armed) begin
          accept_start = 1'b1;
          next_state   = LOAD;
        end
      end
      LOAD:   next_state = WARMUP;
      WARMUP: begin
        core_enable = 1'b1;
        if (warm_done) next_state = RUN;
      end
      RUN: begin
        core_enable = !(out_valid && !out_ready && word_last);
        if (limit_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // start_armed masks a start that coincides with the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_armed <= 1'b0;
      core_key    <= '0;
      core_iv     <= '0;
      warm_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
      len_lat     <= '0;
      hs_cnt      <= '0;
      done        <= 1'b0;
`endif
    end else begin
      start_armed <= 1'b1;
`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
      done        <= 1'b0;
`endif
      if (accept_start) begin
        core_key <= key;
        core_iv  <= iv;
`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
        len_lat  <= len_words;
        hs_cnt   <= '0;
`endif
      end
      if (abort || limit_hit) begin
        out_valid <= 1'b0;
        bit_cnt   <= '0;
        warm_cnt  <= '0;
`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
        done      <= limit_hit && !abort;
`endif
      end else begin
        if (state == WARMUP)
          warm_cnt <= warm_done ? '0 : warm_cnt + WCNT_W'(1);
        if (state == RUN) begin
          if (core_enable) begin
            shift <= shift_next[WORD_W-2:0];
            if (word_last) begin
              out_data  <= shift_next;
              out_valid <= 1'b1;
              bit_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + BCNT_W'(1);
              if (handshake) out_valid <= 1'b0;
            end
          end else if (handshake) begin
            out_valid <= 1'b0;
          end
`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
          if (handshake) hs_cnt <= hs_cnt + 16'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_trivium_ctrl.sv
// Testbench for trivium_ctrl: a stub core replays a known bit stream after its warm-up rounds,
// and received words are compared with that stream packed MSB-first.
module tb_trivium_ctrl;

  localparam int WORD_W = 8;
  localparam int WARM   = 1152;
  localparam int PAT_N  = 4096;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              start     = 1'b0;
  logic              stop      = 1'b0;
  logic [79:0]       key       = '0;
  logic [79:0]       iv        = '0;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              core_load;
  logic              core_enable;
  logic              core_ks_bit;
  logic              out_valid;
  logic [79:0]       core_key;
  logic [79:0]       core_iv;
  logic [WORD_W-1:0] out_data;
`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
  logic [15:0]       len_words = 16'd0;
  logic              done;
`endif

  int pass_cnt    = 0;
  int total_cnt   = 0;
  int cyc         = 0;
  int rounds      = 0;
  int hold_breaks = 0;
  bit pat [PAT_N];
  logic junk = 1'b0;

  logic [WORD_W-1:0] seen_q[$];
  int                seen_cyc[$];
  logic              prev_stall = 1'b0;
  logic              prev_stop  = 1'b0;
  logic [WORD_W-1:0] prev_data  = '0;

  trivium_ctrl #(.WORD_W(WORD_W), .WARMUP_CYCLES(WARM), .WCNT_W(11)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .key(key), .iv(iv),
    .busy(busy), .core_load(core_load), .core_key(core_key), .core_iv(core_iv),
    .core_enable(core_enable), .core_ks_bit(core_ks_bit),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
    , .len_words(len_words), .done(done)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub core: counts rounds since load; rounds past the warm-up replay pat[], earlier ones are noise
  always @(posedge clk) begin
    junk <= 1'($urandom);
    if (core_load)        rounds <= 0;
    else if (core_enable) rounds <= rounds + 1;
  end
  assign core_ks_bit = (rounds >= WARM) ? pat[(rounds - WARM) % PAT_N] : junk;

  // Record every transfer and any change of a word that was stalled
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        seen_q.push_back(out_data);
        seen_cyc.push_back(cyc);
      end
      if (prev_stall && !prev_stop && (!out_valid || out_data !== prev_data)) hold_breaks++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_stop  = stop;
    end
  end

  function automatic logic [WORD_W-1:0] exp_word(int k);
    int w = 0;
    for (int i = 0; i < WORD_W; i++) w = w * 2 + int'(pat[(k * WORD_W + i) % PAT_N]);
    return WORD_W'(w);
  endfunction

  function automatic logic [79:0] rand80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); stop = 1'($urandom); out_ready = 1'($urandom);
      key = rand80(); iv = rand80();
      @(negedge clk);
      total_cnt++;
      if ({busy, core_load, core_enable, out_valid, out_data, core_key, core_iv} !== '0)
        $display("[TB] FAIL reset_outputs: got %h, expected 0",
                 {busy, core_load, core_enable, out_valid, out_data, core_key, core_iv});
      else pass_cnt++;
`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
      total_cnt++;
      if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b, expected 0", done);
      else pass_cnt++;
`endif
      next_cycle();
    end
    start = 1'b1; stop = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL start_at_release_busy: got %b, expected 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (core_load !== 1'b0) $display("[TB] FAIL start_at_release_load: got %b, expected 0", core_load);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_startup(output int fv, output int base);
    int t, load_at, load_cnt, en_cnt;
    logic en_load, busy_load;
    logic [79:0] k, v;
    base = seen_q.size();
    k = rand80(); v = rand80();
    key = k; iv = v; out_ready = 1'b1; start = 1'b1; t = cyc;
    next_cycle();
    start = 1'b0; key = rand80(); iv = rand80();
    load_at = -1; load_cnt = 0; en_cnt = 0; en_load = 1'b1; busy_load = 1'b0; fv = -1;
    for (int i = 0; i < 1300 && fv < 0; i++) begin
      @(negedge clk);
      if (core_load) begin
        load_cnt++;
        if (load_at < 0) load_at = cyc;
      end
      if (cyc == t + 1) begin en_load = core_enable; busy_load = busy; end
      if (core_enable && cyc >= t + 2 && cyc <= t + WARM + 1) en_cnt++;
      if (out_valid) fv = cyc;
      next_cycle();
    end
    total_cnt++;
    if (load_at !== t + 1) $display("[TB] FAIL load_cycle: got %0d, expected %0d", load_at, t + 1);
    else pass_cnt++;
    total_cnt++;
    if (load_cnt !== 1) $display("[TB] FAIL load_count: got %0d, expected 1", load_cnt);
    else pass_cnt++;
    total_cnt++;
    if (en_load !== 1'b0) $display("[TB] FAIL enable_during_load: got %b, expected 0", en_load);
    else pass_cnt++;
    total_cnt++;
    if (busy_load !== 1'b1) $display("[TB] FAIL busy_during_load: got %b, expected 1", busy_load);
    else pass_cnt++;
    total_cnt++;
    if (en_cnt !== WARM) $display("[TB] FAIL warmup_enables: got %0d, expected %0d", en_cnt, WARM);
    else pass_cnt++;
    total_cnt++;
    if (fv !== t + 2 + WARM + WORD_W)
      $display("[TB] FAIL first_valid_cycle: got %0d, expected %0d", fv, t + 2 + WARM + WORD_W);
    else pass_cnt++;
    total_cnt++;
    if (core_key !== k) $display("[TB] FAIL latched_key: got %h, expected %h", core_key, k);
    else pass_cnt++;
    total_cnt++;
    if (core_iv !== v) $display("[TB] FAIL latched_iv: got %h, expected %h", core_iv, v);
    else pass_cnt++;
  endtask

  task automatic test_words(input int fv, input int base);
    int nv, n;
    logic v_after;
    nv = 0; v_after = 1'b1;
    for (int i = 0; i < 3 * WORD_W; i++) begin
      @(negedge clk);
      if (cyc == fv + 1) v_after = out_valid;
      if (out_valid) nv++;
      next_cycle();
    end
    n = seen_q.size() - base;
    total_cnt++;
    if (n !== 4) $display("[TB] FAIL words_count: got %0d, expected 4", n);
    else pass_cnt++;
    total_cnt++;
    if (v_after !== 1'b0) $display("[TB] FAIL valid_one_cycle: got %b, expected 0", v_after);
    else pass_cnt++;
    total_cnt++;
    if (nv !== 3) $display("[TB] FAIL valid_cycles: got %0d, expected 3", nv);
    else pass_cnt++;
    if (n >= 4) begin
      total_cnt++;
      if (seen_q[base] !== 8'hB2) $display("[TB] FAIL word0: got %h, expected b2", seen_q[base]);
      else pass_cnt++;
      total_cnt++;
      if (seen_q[base+1] !== 8'hF0) $display("[TB] FAIL word1: got %h, expected f0", seen_q[base+1]);
      else pass_cnt++;
      total_cnt++;
      if (seen_cyc[base+1] - seen_cyc[base] !== WORD_W)
        $display("[TB] FAIL word_spacing: got %0d, expected %0d", seen_cyc[base+1] - seen_cyc[base], WORD_W);
      else pass_cnt++;
      for (int i = 2; i < 4; i++) begin
        total_cnt++;
        if (seen_q[base+i] !== exp_word(i))
          $display("[TB] FAIL word%0d: got %h, expected %h", i, seen_q[base+i], exp_word(i));
        else pass_cnt++;
      end
    end
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    next_cycle();
  endtask

  task automatic test_backpressure();
    int t, fv, base, hb0, held, en_in_stall, drop_at, n;
    base = seen_q.size(); hb0 = hold_breaks;
    out_ready = 1'b0; key = rand80(); iv = rand80(); start = 1'b1; t = cyc;
    next_cycle();
    start = 1'b0;
    fv = t + 2 + WARM + WORD_W;
    while (cyc < fv) next_cycle();
    held = 0; en_in_stall = 0; drop_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid && out_data === 8'hB2) held++;
      if (core_enable) en_in_stall++;
      else if (drop_at < 0) drop_at = cyc;
      next_cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3 * WORD_W; i++) next_cycle();
    total_cnt++;
    if (held !== 20) $display("[TB] FAIL stall_hold: got %0d cycles, expected 20", held);
    else pass_cnt++;
    total_cnt++;
    if (drop_at !== fv + WORD_W - 1)
      $display("[TB] FAIL stall_drop_cycle: got %0d, expected %0d", drop_at, fv + WORD_W - 1);
    else pass_cnt++;
    total_cnt++;
    if (en_in_stall !== WORD_W - 1)
      $display("[TB] FAIL stall_enables: got %0d, expected %0d", en_in_stall, WORD_W - 1);
    else pass_cnt++;
    total_cnt++;
    if (hold_breaks - hb0 !== 0) $display("[TB] FAIL stall_stability: got %0d breaks, expected 0", hold_breaks - hb0);
    else pass_cnt++;
    n = seen_q.size() - base;
    total_cnt++;
    if (n < 3) $display("[TB] FAIL bp_words_count: got %0d, expected at least 3", n);
    else pass_cnt++;
    if (n >= 3) begin
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (seen_q[base+i] !== exp_word(i))
          $display("[TB] FAIL bp_word%0d: got %h, expected %h", i, seen_q[base+i], exp_word(i));
        else pass_cnt++;
      end
      total_cnt++;
      if (seen_cyc[base+1] - seen_cyc[base] !== 1)
        $display("[TB] FAIL bp_no_gap: got %0d, expected 1", seen_cyc[base+1] - seen_cyc[base]);
      else pass_cnt++;
    end
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    next_cycle();
  endtask

  task automatic test_stop();
    int t, s, t2, base, load_at, fv;
    logic [79:0] k1, k2;
    k1 = rand80(); key = k1; iv = rand80(); out_ready = 1'b1; start = 1'b1; t = cyc;
    next_cycle();
    start = 1'b0;
    while (cyc < t + 2 + 500) next_cycle();
    stop = 1'b1; s = cyc;
    next_cycle();
    stop = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || core_enable !== 1'b0)
      $display("[TB] FAIL stop_idle: got busy=%b enable=%b at cycle %0d, expected 0 0", busy, core_enable, s + 1);
    else pass_cnt++;
    total_cnt++;
    if (core_key !== k1) $display("[TB] FAIL stop_keeps_key: got %h, expected %h", core_key, k1);
    else pass_cnt++;
    next_cycle();
    base = seen_q.size();
    k2 = rand80(); key = k2; start = 1'b1; stop = 1'b1; t2 = cyc;
    next_cycle();
    start = 1'b0; stop = 1'b0;
    load_at = -1; fv = -1;
    for (int i = 0; i < 1300 && fv < 0; i++) begin
      @(negedge clk);
      if (core_load && load_at < 0) load_at = cyc;
      if (out_valid) fv = cyc;
      next_cycle();
      start = (cyc == t2 + 100);
      if (start) key = rand80();
    end
    start = 1'b0;
    total_cnt++;
    if (load_at !== t2 + 1) $display("[TB] FAIL restart_load: got %0d, expected %0d", load_at, t2 + 1);
    else pass_cnt++;
    total_cnt++;
    if (fv !== t2 + 2 + WARM + WORD_W)
      $display("[TB] FAIL restart_first_valid: got %0d, expected %0d", fv, t2 + 2 + WARM + WORD_W);
    else pass_cnt++;
    total_cnt++;
    if (core_key !== k2) $display("[TB] FAIL start_while_busy: got %h, expected %h", core_key, k2);
    else pass_cnt++;
    total_cnt++;
    if (seen_q.size() <= base || seen_q[base] !== 8'hB2)
      $display("[TB] FAIL restart_word0: got %0d words, expected first word b2", seen_q.size() - base);
    else pass_cnt++;
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    next_cycle();
  endtask

  task automatic test_random();
    int base, hb0, n, bad, first_bad;
    base = seen_q.size(); hb0 = hold_breaks;
    key = rand80(); iv = rand80(); start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < WARM + 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    out_ready = 1'b0; stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL stop_clears_valid: got valid=%b busy=%b, expected 0 0", out_valid, busy);
    else pass_cnt++;
    n = seen_q.size() - base;
    total_cnt++;
    if (n < 20) $display("[TB] FAIL random_word_count: got %0d, expected at least 20", n);
    else pass_cnt++;
    bad = 0; first_bad = -1;
    for (int i = 0; i < n; i++) begin
      if (seen_q[base+i] !== exp_word(i)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    total_cnt++;
    if (bad !== 0) $display("[TB] FAIL random_words: got %0d wrong (first at %0d), expected 0", bad, first_bad);
    else pass_cnt++;
    total_cnt++;
    if (hold_breaks - hb0 !== 0) $display("[TB] FAIL random_stability: got %0d breaks, expected 0", hold_breaks - hb0);
    else pass_cnt++;
    next_cycle();
  endtask

`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
  task automatic test_len_limit();
    int base, n, done_at, done_cnt, after_bad;
    base = seen_q.size();
    len_words = 16'd3; out_ready = 1'b1; key = rand80(); start = 1'b1;
    next_cycle();
    start = 1'b0; len_words = 16'd0;
    done_at = -1; done_cnt = 0; after_bad = 0;
    for (int i = 0; i < WARM + 60; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && (busy || core_enable)) after_bad++;
      next_cycle();
    end
    n = seen_q.size() - base;
    total_cnt++;
    if (n !== 3) $display("[TB] FAIL len_handshakes: got %0d, expected 3", n);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1) $display("[TB] FAIL done_width: got %0d, expected 1", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (n < 3 || done_at !== seen_cyc[base+2] + 1)
      $display("[TB] FAIL done_cycle: got %0d, expected one after third transfer", done_at);
    else pass_cnt++;
    total_cnt++;
    if (after_bad !== 0) $display("[TB] FAIL len_idle_after: got %0d busy cycles, expected 0", after_bad);
    else pass_cnt++;
  endtask
`endif

  initial begin
    int fv, base;
    logic [15:0] head;
    head = 16'hB2F0;
    for (int i = 0; i < PAT_N; i++) pat[i] = (i < 16) ? head[15-i] : 1'($urandom);
    #2;
    test_reset();
    test_startup(fv, base);
    test_words(fv, base);
    test_backpressure();
    test_stop();
    test_random();
`ifdef TRIVIUM_CTRL_LEN_LIMIT_EN
    test_len_limit();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
